// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM state encoding,
// the registered memory request record and the fetch byte-enable constant.
package riscv_mem_pkg;

  localparam int MEM_AW  = 32;
  localparam int MEM_DW  = 32;
  localparam int MEM_BEW = MEM_DW / 8;

  localparam logic [MEM_BEW-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               we;
    logic [MEM_AW-1:0]  addr;
    logic [MEM_DW-1:0]  wdata;
    logic [MEM_BEW-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one variable-latency
// memory port, with fixed data priority, done pulses and a timeout abort.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW      = MEM_AW,
  parameter int DW      = MEM_DW,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output arb_state_t    dbg_state
);

  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Handshake: a port raises x_req and holds it with its operands stable until
  // the one-cycle x_done pulse; the memory sees mem_req high for the whole
  // access and completes it on the first edge where mem_ready is high.

  arb_state_t          state_q, state_d;
  mem_req_t            mreq_q, mreq_d;
  logic [DW-1:0]       if_rdata_q, if_rdata_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    mreq_d     = mreq_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A port whose done is pulsing this cycle is already served; skip it.
        if (d_req && !d_done_q) begin
          mreq_d.we    = d_we;
          mreq_d.addr  = MEM_AW'(d_addr);
          mreq_d.wdata = MEM_DW'(d_wdata);
          mreq_d.be    = MEM_BEW'(d_be);
          state_d      = BUSY_D;
        end else if (if_req && !if_done_q) begin
          mreq_d.we    = 1'b0;
          mreq_d.addr  = MEM_AW'(if_addr);
          mreq_d.wdata = '0;
          mreq_d.be    = BE_ALL;
          state_d      = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == BUSY_I) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_done_d = 1'b1;
            if (!mreq_q.we) d_rdata_d = mem_ready ? mem_rdata : '0;
          end
          if (!mem_ready) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mreq_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mreq_q     <= mreq_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mreq_q.we;
  assign mem_addr  = AW'(mreq_q.addr);
  assign mem_wdata = DW'(mreq_q.wdata);
  assign mem_be    = BW'(mreq_q.be);

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Stalls depend only on the request inputs and registered done pulses.
  assign if_stall  = if_req & ~if_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model,
// a per-cycle compare loop, an issued-address scoreboard and pinned literals.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, d_done, d_stall, mem_req, mem_we, err;
  logic [3:0]  mem_be;
  arb_state_t  dbg_state;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=still_running req=finished");
    $fatal(1);
  end

  // ---------------- counters and scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  bit   tests_done = 0;
  bit   started = 0;
  int   stall_cnt, hold_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h00500113;
      32'h4:   rom = 32'h00a00193;
      32'h100: rom = 32'h12345678;
      default: rom = a ^ 32'hA5A50000;
    endcase
  endfunction

  // ---------------- memory responder ----------------
  int lat;        // wait cycles with mem_ready low before the ready cycle
  int seen;
  bit idle_ready; // also drive mem_ready while no access is outstanding

  always @(posedge clk) begin
    if (!mem_req || mem_ready) seen = 0;
    else seen++;
  end

  always @(negedge clk) begin
    #2;
    if (mem_req && seen >= lat) begin
      mem_ready = 1'b1;
      mem_rdata = rom(mem_addr);
    end else begin
      mem_ready = !mem_req && idle_ready;
      mem_rdata = $urandom;
    end
  end

  // ---------------- reference model ----------------
  // One outstanding access at most; rules: data first, a port is not
  // re-served in its done cycle, abort after TO silent busy cycles.
  bit          m_busy, m_port_d, m_we;
  int          m_wait;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        e_if_done, e_d_done, e_err;
  logic [31:0] e_if_rdata, e_d_rdata;

  task automatic model_finish(input logic [31:0] data);
    m_busy = 0;
    if (m_port_d) begin
      e_d_done = 1'b1;
      if (!m_we) e_d_rdata = data;
    end else begin
      e_if_done  = 1'b1;
      e_if_rdata = data;
    end
  endtask

  always @(posedge clk) begin
    bit was_i, was_d;
    started = 1;
    if (reset) begin
      m_busy = 0; m_port_d = 0; m_we = 0; m_wait = 0;
      m_addr = 0; m_wdata = 0; m_be = 0;
      e_if_done = 0; e_d_done = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
    end else begin
      was_i = e_if_done;
      was_d = e_d_done;
      e_if_done = 0;
      e_d_done  = 0;
      if (!m_busy) begin
        if (d_req && !was_d) begin
          m_busy = 1; m_port_d = 1; m_we = d_we; m_addr = d_addr;
          m_wdata = d_wdata; m_be = d_be; m_wait = 0;
        end else if (if_req && !was_i) begin
          m_busy = 1; m_port_d = 0; m_we = 0; m_addr = if_addr;
          m_wdata = 0; m_be = 4'hF; m_wait = 0;
        end
      end else if (mem_ready) begin
        model_finish(mem_rdata);
      end else if (TO > 0 && m_wait + 1 >= TO) begin
        model_finish(32'h0);
        e_err = 1'b1;
      end else begin
        m_wait++;
      end
    end
  end

  // ---------------- per-cycle compare and address monitor ----------------
  task automatic compare_loop();
    bit prev_req = 0;
    while (!tests_done) begin
      @(negedge clk);
      if (started) begin
        check("if_done", if_done, e_if_done);
        check("d_done", d_done, e_d_done);
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        check("if_stall", if_stall, if_req & ~e_if_done);
        check("d_stall", d_stall, d_req & ~e_d_done);
        check("mem_req", mem_req, m_busy);
        check("state_busy", dbg_state != IDLE, m_busy);
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_be", mem_be, m_be);
        if (m_port_d) check("mem_wdata", mem_wdata, m_wdata);
        check("err", err, e_err);
        if (if_stall) stall_cnt++;
        if (mem_req && mem_we && mem_be == 4'b0011 && mem_wdata == 32'hDEADBEEF && mem_addr == 32'h20)
          hold_cnt++;
        if (mem_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL txn_extra act=%0h req=no_access t=%0t", mem_addr, $time);
          end else begin
            check("txn_addr", mem_addr, exp_q.pop_front());
          end
        end
        prev_req = mem_req;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Counts negedges from the request until each wanted done, dropping the
  // request right after its done pulse is seen.
  task automatic wait_dones(input bit want_i, input bit want_d, output int ci, output int cd);
    bit got_i, got_d;
    int n;
    got_i = !want_i; got_d = !want_d; ci = -1; cd = -1; n = 0;
    while (!(got_i && got_d) && n < 200) begin
      @(negedge clk);
      n++;
      if (!got_i && if_done) begin got_i = 1; ci = n; end
      if (!got_d && d_done)  begin got_d = 1; cd = n; end
      #1;
      if (want_i && got_i) if_req = 1'b0;
      if (want_d && got_d) d_req = 1'b0;
    end
    if (!(got_i && got_d)) begin
      total++; bad++;
      $display("FAIL wait_done act=timeout req=done_within_200 t=%0t", $time);
      if_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic start_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_we = we; d_addr = a; d_wdata = wd; d_be = be; d_req = 1'b1;
    exp_q.push_back(a);
  endtask

  task automatic start_fetch(input logic [31:0] a);
    if_addr = a; if_req = 1'b1;
    exp_q.push_back(a);
  endtask

  // ---------------- directed tests ----------------
  task automatic run_tests();
    int ci, cd;
    repeat (3) @(negedge clk);
    check("rst_if_done", if_done, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_err", err, 1'b0);
    check("rst_d_rdata", d_rdata, 32'h0);
    #1 reset = 1'b0;
    idle(1);

    // 1: single fetch, one wait cycle
    lat = 1; stall_cnt = 0;
    start_fetch(32'h0);
    wait_dones(1, 0, ci, cd);
    check("t1_latency", ci, 3);
    check("t1_rdata", if_rdata, 32'h00500113);
    check("t1_stall_cycles", stall_cnt, 2);
    idle(1);

    // 2: collision, data served first, fetch granted in the d_done cycle
    lat = 0;
    start_data(1'b0, 32'h100, 32'h0, 4'hF);
    start_fetch(32'h8);
    wait_dones(1, 1, ci, cd);
    check("t2_d_latency", cd, 2);
    check("t2_i_latency", ci, 4);
    check("t2_d_rdata", d_rdata, 32'h12345678);
    check("t2_i_rdata", if_rdata, 32'hA5A50008);
    idle(1);

    // 3: store with three wait cycles
    lat = 3; hold_cnt = 0;
    start_data(1'b1, 32'h20, 32'hDEADBEEF, 4'b0011);
    wait_dones(0, 1, ci, cd);
    check("t3_latency", cd, 5);
    check("t3_hold_cycles", hold_cnt, 4);
    check("t3_d_rdata_kept", d_rdata, 32'h12345678);
    d_we = 1'b0;
    idle(1);

    // 4: back-to-back fetches, stray mem_ready while idle
    lat = 0; idle_ready = 1;
    start_fetch(32'h0);
    wait_dones(1, 0, ci, cd);
    check("t4_first_latency", ci, 2);
    start_fetch(32'h4);
    wait_dones(1, 0, ci, cd);
    check("t4_second_latency", ci, 3);
    check("t4_rdata", if_rdata, 32'h00a00193);
    idle_ready = 0;
    idle(2);
    check("t4_txn_left", exp_q.size(), 0);

    // 5: timeout abort, then a normal access
    lat = 1000;
    start_data(1'b0, 32'h40, 32'h0, 4'hF);
    wait_dones(0, 1, cd, cd);
    check("t5_abort_latency", cd, 9);
    check("t5_d_rdata", d_rdata, 32'h0);
    check("t5_err", err, 1'b1);
    lat = 0;
    start_fetch(32'hC);
    wait_dones(1, 0, ci, cd);
    check("t5_next_latency", ci, 2);
    check("t5_next_rdata", if_rdata, 32'hA5A5000C);
    check("t5_err_sticky", err, 1'b1);
    idle(1);

    // 6: reset while a load is waiting
    lat = 1000;
    start_data(1'b0, 32'h80, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("t6_mem_req", mem_req, 1'b0);
    check("t6_no_done", d_done, 1'b0);
    check("t6_err", err, 1'b0);
    check("t6_idle", dbg_state == IDLE, 1'b1);
    #1 reset = 1'b0;
    idle(1);
    lat = 0;
    start_data(1'b0, 32'h100, 32'h0, 4'hF);
    wait_dones(0, 1, ci, cd);
    check("t6_after_latency", cd, 2);
    check("t6_after_rdata", d_rdata, 32'h12345678);
    idle(2);
    check("txn_left", exp_q.size(), 0);
    tests_done = 1;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ready = 0; mem_rdata = 0;
    lat = 0; seen = 0; idle_ready = 0; stall_cnt = 0; hold_cnt = 0;
    fork
      compare_loop();
      run_tests();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
